// File: rtl/pll_phase_if.sv
// Requester-side handshake bundle for pll_phase_ctrl.
//   master  : the requester (drives ps_req/ps_sel/ps_dir/ps_steps, observes the rest)
//   slave   : the controller (observes the request, drives ps_ack/ps_done/ready)
// Signals:
//   ps_req    level request, only honoured while ready=1
//   ps_sel    PLL output channel to shift (0-6, 7 forwarded as-is)
//   ps_dir    shift direction
//   ps_steps  number of phase steps, 0 = no pulses
//   ps_ack    one-cycle pulse on request accept
//   ps_done   one-cycle pulse when the last step completes
//   ready     PLL locked and qualified, no shift in progress
interface pll_phase_if #(
  parameter int unsigned STEP_W = 8
) ();
  logic              ps_req;
  logic [2:0]        ps_sel;
  logic              ps_dir;
  logic [STEP_W-1:0] ps_steps;
  logic              ps_ack;
  logic              ps_done;
  logic              ready;

  modport master (
    output ps_req, ps_sel, ps_dir, ps_steps,
    input  ps_ack, ps_done, ready
  );

  modport slave (
    input  ps_req, ps_sel, ps_dir, ps_steps,
    output ps_ack, ps_done, ready
  );
endinterface

// File: rtl/pll_phase_ctrl.sv
// PLL reset sequencer, lock qualifier and dynamic phase-shift controller for a GW5A PLLA.
// Runs on the free-running board clock that also feeds the PLL reference input.
// Ports:
//   clkin        controller clock
//   rst          synchronous active-high reset
//   pll_lock     PLL LOCK, asynchronous to clkin (2-flop synchronised internally)
//   pll_reset    PLL RESET
//   pll_pssel    PLL PSSEL, latched channel of the accepted request
//   pll_psdir    PLL PSDIR, latched direction of the accepted request
//   pll_pspulse  PLL PSPULSE, PS_HALF cycles high then PS_HALF low per step
//   ps           requester handshake (pll_phase_if.slave)
//   user_rst     synchronous reset for the PLL output clock domains
//   relock_cnt   saturating count of lock losses and lock timeouts
//   phase_pos    (only with PLL_PHASE_TRACK_EN) signed per-channel step position,
//                7 fields of STEP_W bits, channel n at [n*STEP_W +: STEP_W]
// Optional feature macro: PLL_PHASE_TRACK_EN
module pll_phase_ctrl #(
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_STABLE  = 8,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned PS_HALF      = 4,
  parameter int unsigned STEP_W       = 8
) (
  input  logic                clkin,
  input  logic                rst,
  input  logic                pll_lock,
  output logic                pll_reset,
  output logic [2:0]          pll_pssel,
  output logic                pll_psdir,
  output logic                pll_pspulse,
  pll_phase_if.slave          ps,
  output logic                user_rst,
  output logic [7:0]          relock_cnt
`ifdef PLL_PHASE_TRACK_EN
  ,
  output logic [7*STEP_W-1:0] phase_pos
`endif
);

  // One shared counter serves every timed state, so size it for the longest interval.
  localparam int unsigned MaxA   = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxB   = (MaxA > LOCK_STABLE) ? MaxA : LOCK_STABLE;
  localparam int unsigned CntMax = (MaxB > PS_HALF) ? MaxB : PS_HALF;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] RstLast  = CntW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0] ToLast   = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StbLast  = CntW'(LOCK_STABLE - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(PS_HALF - 1);

  typedef enum logic [2:0] {
    StRstHold,
    StWaitLock,
    StQualify,
    StReady,
    StPsHi,
    StPsLo,
    StPsEnd
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [STEP_W-1:0] steps_q;
  logic              lock_meta;
  logic              lock_s;

  // Lock is only supervised once the PLL has been qualified.
  logic lock_lost;
  assign lock_lost = !lock_s &&
                     ((state_q == StReady) || (state_q == StPsHi) ||
                      (state_q == StPsLo)  || (state_q == StPsEnd));

  always_ff @(posedge clkin) begin
    if (rst) begin
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      state_q     <= StRstHold;
      cnt_q       <= '0;
      steps_q     <= '0;
      pll_reset   <= 1'b1;
      pll_pssel   <= 3'd0;
      pll_psdir   <= 1'b0;
      pll_pspulse <= 1'b0;
      ps.ps_ack   <= 1'b0;
      ps.ps_done  <= 1'b0;
      ps.ready    <= 1'b0;
      user_rst    <= 1'b1;
      relock_cnt  <= 8'd0;
`ifdef PLL_PHASE_TRACK_EN
      phase_pos   <= '0;
`endif
    end else begin
      lock_meta  <= pll_lock;
      lock_s     <= lock_meta;
      ps.ps_ack  <= 1'b0;
      ps.ps_done <= 1'b0;

      if (lock_lost) begin
        // Abort any shift in flight and restart the PLL; no ps_done is issued.
        state_q     <= StRstHold;
        cnt_q       <= '0;
        pll_reset   <= 1'b1;
        pll_pspulse <= 1'b0;
        ps.ready    <= 1'b0;
        user_rst    <= 1'b1;
        if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
`ifdef PLL_PHASE_TRACK_EN
        phase_pos   <= '0;
`endif
      end else begin
        unique case (state_q)
          StRstHold: begin
            if (cnt_q == RstLast) begin
              state_q   <= StWaitLock;
              cnt_q     <= '0;
              pll_reset <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end

          StWaitLock: begin
            if (lock_s) begin
              // This sample already counts as the first stable-lock cycle.
              cnt_q <= CntW'(1);
              if (LOCK_STABLE <= 1) begin
                state_q  <= StReady;
                ps.ready <= 1'b1;
                user_rst <= 1'b0;
              end else begin
                state_q <= StQualify;
              end
            end else if (cnt_q == ToLast) begin
              state_q   <= StRstHold;
              cnt_q     <= '0;
              pll_reset <= 1'b1;
              if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
`ifdef PLL_PHASE_TRACK_EN
              phase_pos <= '0;
`endif
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end

          StQualify: begin
            if (!lock_s) begin
              cnt_q <= '0;
            end else if (cnt_q == StbLast) begin
              state_q  <= StReady;
              cnt_q    <= '0;
              ps.ready <= 1'b1;
              user_rst <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end

          StReady: begin
            if (ps.ps_req) begin
              ps.ps_ack <= 1'b1;
              ps.ready  <= 1'b0;
              pll_pssel <= ps.ps_sel;
              pll_psdir <= ps.ps_dir;
              steps_q   <= ps.ps_steps;
              cnt_q     <= '0;
              if (ps.ps_steps == '0) begin
                state_q <= StPsEnd;
              end else begin
                state_q     <= StPsHi;
                pll_pspulse <= 1'b1;
              end
            end
          end

          StPsHi: begin
            if (cnt_q == HalfLast) begin
              state_q     <= StPsLo;
              cnt_q       <= '0;
              pll_pspulse <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end

          StPsLo: begin
            if (cnt_q == HalfLast) begin
              cnt_q   <= '0;
              steps_q <= steps_q - STEP_W'(1);
              if (steps_q == STEP_W'(1)) begin
                state_q <= StPsEnd;
              end else begin
                state_q     <= StPsHi;
                pll_pspulse <= 1'b1;
              end
`ifdef PLL_PHASE_TRACK_EN
              // Channel 7 has no tracking field.
              if (pll_pssel != 3'd7) begin
                if (pll_psdir) begin
                  phase_pos[pll_pssel*STEP_W +: STEP_W] <=
                    phase_pos[pll_pssel*STEP_W +: STEP_W] + STEP_W'(1);
                end else begin
                  phase_pos[pll_pssel*STEP_W +: STEP_W] <=
                    phase_pos[pll_pssel*STEP_W +: STEP_W] - STEP_W'(1);
                end
              end
`endif
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end

          StPsEnd: begin
            state_q    <= StReady;
            ps.ps_done <= 1'b1;
            ps.ready   <= 1'b1;
          end

          default: begin
            state_q   <= StRstHold;
            cnt_q     <= '0;
            pll_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
module tb_pll_phase_ctrl;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       pll_reset;
  logic [2:0] pll_pssel;
  logic       pll_psdir;
  logic       pll_pspulse;
  logic       user_rst;
  logic [7:0] relock_cnt;
`ifdef PLL_PHASE_TRACK_EN
  logic [55:0] phase_pos;
`endif

  int total;
  int bad;

  pll_phase_if #(.STEP_W(8)) ps_bus ();

  pll_phase_ctrl #(
    .RESET_CYCLES (16),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (100),
    .PS_HALF      (4),
    .STEP_W       (8)
  ) dut (
    .clkin       (clk),
    .rst         (rst),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .pll_pssel   (pll_pssel),
    .pll_psdir   (pll_psdir),
    .pll_pspulse (pll_pspulse),
    .ps          (ps_bus),
    .user_rst    (user_rst),
    .relock_cnt  (relock_cnt)
`ifdef PLL_PHASE_TRACK_EN
    ,
    .phase_pos   (phase_pos)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one request from READY and follows it to ps_done.
  task automatic do_shift(input string tag, input logic [2:0] sel, input logic dir,
                          input logic [7:0] steps, input int exp_rises, input int exp_high,
                          input int exp_lat);
    int   rises;
    int   high;
    int   lat;
    logic prev;
    logic sel_ok;
    logic dir_ok;
    check({tag, "_ready_before"}, 64'(ps_bus.ready), 64'd1);
    ps_bus.ps_sel   = sel;
    ps_bus.ps_dir   = dir;
    ps_bus.ps_steps = steps;
    ps_bus.ps_req   = 1'b1;
    tick();
    ps_bus.ps_req = 1'b0;
    check({tag, "_ack"}, 64'(ps_bus.ps_ack), 64'd1);
    check({tag, "_ready_at_ack"}, 64'(ps_bus.ready), 64'd0);
    rises  = 0;
    high   = 0;
    prev   = 1'b0;
    sel_ok = 1'b1;
    dir_ok = 1'b1;
    lat    = -1;
    if (pll_pspulse) begin
      high++;
      rises++;
    end
    prev = pll_pspulse;
    for (int k = 1; k <= 600; k++) begin
      tick();
      if (pll_pssel !== sel) sel_ok = 1'b0;
      if (pll_psdir !== dir) dir_ok = 1'b0;
      if (pll_pspulse) high++;
      if (pll_pspulse && !prev) rises++;
      prev = pll_pspulse;
      if (ps_bus.ps_done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_done_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_pulse_count"}, 64'(rises), 64'(exp_rises));
    check({tag, "_pulse_high_cycles"}, 64'(high), 64'(exp_high));
    check({tag, "_pssel_stable"}, 64'(sel_ok), 64'd1);
    check({tag, "_psdir_stable"}, 64'(dir_ok), 64'd1);
    check({tag, "_ready_at_done"}, 64'(ps_bus.ready), 64'd1);
  endtask

  typedef struct {
    logic [2:0] sel;
    logic       dir;
    logic [7:0] steps;
    int         rises;
    int         high;
    int         lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   n;
    int   n1;
    logic prev_ur;
    logic done_seen;

    total = 0;
    bad   = 0;
    vecs[0] = '{sel: 3'd1, dir: 1'b1, steps: 8'd3, rises: 3, high: 12, lat: 25};
    vecs[1] = '{sel: 3'd0, dir: 1'b0, steps: 8'd0, rises: 0, high: 0,  lat: 1};
    vecs[2] = '{sel: 3'd6, dir: 1'b0, steps: 8'd1, rises: 1, high: 4,  lat: 9};
    vecs[3] = '{sel: 3'd7, dir: 1'b1, steps: 8'd2, rises: 2, high: 8,  lat: 17};
    vecs[4] = '{sel: 3'd3, dir: 1'b0, steps: 8'd5, rises: 5, high: 20, lat: 41};

    rst             = 1'b1;
    pll_lock        = 1'b0;
    ps_bus.ps_req   = 1'b0;
    ps_bus.ps_sel   = 3'd0;
    ps_bus.ps_dir   = 1'b0;
    ps_bus.ps_steps = 8'd0;

    // Power-up
    tick();
    check("rst_pll_reset", 64'(pll_reset), 64'd1);
    check("rst_user_rst", 64'(user_rst), 64'd1);
    check("rst_ready", 64'(ps_bus.ready), 64'd0);
    check("rst_relock_cnt", 64'(relock_cnt), 64'd0);
    check("rst_pspulse", 64'(pll_pspulse), 64'd0);
    check("rst_pssel", 64'(pll_pssel), 64'd0);
    check("rst_psdir", 64'(pll_psdir), 64'd0);
    check("rst_ack_done", 64'({ps_bus.ps_ack, ps_bus.ps_done}), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (!pll_reset) begin
        n = k;
        break;
      end
    end
    check("pu_reset_high_cycles", 64'(n), 64'd16);
    repeat (24) tick();
    pll_lock = 1'b1;
    n = -1;
    prev_ur = user_rst;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (ps_bus.ready) begin
        n = k;
        break;
      end
      prev_ur = user_rst;
    end
    check("pu_ready_latency", 64'(n), 64'd10);
    check("pu_user_rst_before", 64'(prev_ur), 64'd1);
    check("pu_user_rst_after", 64'(user_rst), 64'd0);
    check("pu_relock_cnt", 64'(relock_cnt), 64'd0);

    // Directed shift table
    foreach (vecs[i]) begin
      do_shift($sformatf("vec%0d", i), vecs[i].sel, vecs[i].dir, vecs[i].steps,
               vecs[i].rises, vecs[i].high, vecs[i].lat);
    end

    // ps_req held through ps_done re-triggers one cycle after READY
    ps_bus.ps_sel   = 3'd4;
    ps_bus.ps_dir   = 1'b1;
    ps_bus.ps_steps = 8'd1;
    ps_bus.ps_req   = 1'b1;
    tick();
    check("hold_ack1", 64'(ps_bus.ps_ack), 64'd1);
    n = -1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (ps_bus.ps_done) begin
        n = k;
        break;
      end
    end
    check("hold_done1_latency", 64'(n), 64'd9);
    tick();
    ps_bus.ps_req = 1'b0;
    check("hold_retrigger_ack", 64'(ps_bus.ps_ack), 64'd1);
    n = -1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (ps_bus.ps_done) begin
        n = k;
        break;
      end
    end
    check("hold_done2_latency", 64'(n), 64'd9);

    // Lock drop during the second step
    ps_bus.ps_sel   = 3'd5;
    ps_bus.ps_dir   = 1'b0;
    ps_bus.ps_steps = 8'd3;
    ps_bus.ps_req   = 1'b1;
    tick();
    ps_bus.ps_req = 1'b0;
    check("drop_ack", 64'(ps_bus.ps_ack), 64'd1);
    repeat (9) tick();
    check("drop_in_step2_pulse", 64'(pll_pspulse), 64'd1);
    pll_lock  = 1'b0;
    done_seen = 1'b0;
    n = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (ps_bus.ps_done) done_seen = 1'b1;
      if (pll_reset) begin
        n = k;
        break;
      end
    end
    check("drop_detect_latency", 64'(n), 64'd3);
    check("drop_pspulse_low", 64'(pll_pspulse), 64'd0);
    check("drop_user_rst", 64'(user_rst), 64'd1);
    check("drop_ready", 64'(ps_bus.ready), 64'd0);
    check("drop_relock_cnt", 64'(relock_cnt), 64'd1);
    pll_lock = 1'b1;
    n = -1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (ps_bus.ps_done) done_seen = 1'b1;
      if (!pll_reset) begin
        n = k;
        break;
      end
    end
    check("drop_reset_high_cycles", 64'(n), 64'd16);
    n = -1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (ps_bus.ps_done) done_seen = 1'b1;
      if (ps_bus.ready) begin
        n = k;
        break;
      end
    end
    check("drop_relock_ready_latency", 64'(n), 64'd8);
    check("drop_no_done", 64'(done_seen), 64'd0);
    check("drop_user_rst_released", 64'(user_rst), 64'd0);

`ifdef PLL_PHASE_TRACK_EN
    check("trk_cleared_after_relock", 64'(phase_pos), 64'd0);
    do_shift("trk_up", 3'd2, 1'b1, 8'd5, 5, 20, 41);
    do_shift("trk_dn", 3'd2, 1'b0, 8'd2, 2, 8, 17);
    check("trk_field2_is_3", 64'(phase_pos), 64'h0000_0000_0003_0000);
`endif

    // Lock loss followed by timeouts and saturation
    pll_lock = 1'b0;
    n = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (pll_reset) begin
        n = k;
        break;
      end
    end
    check("to_detect_latency", 64'(n), 64'd3);
    check("to_relock_cnt2", 64'(relock_cnt), 64'd2);
`ifdef PLL_PHASE_TRACK_EN
    check("trk_cleared_on_rst_hold", 64'(phase_pos), 64'd0);
`endif
    n = -1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (!pll_reset) begin
        n = k;
        break;
      end
    end
    check("to_reset_high_cycles", 64'(n), 64'd16);
    n = -1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (pll_reset) begin
        n = k;
        break;
      end
    end
    check("to_wait_cycles", 64'(n), 64'd100);
    check("to_relock_cnt3", 64'(relock_cnt), 64'd3);
    n1 = -1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (!pll_reset) begin
        n1 = k;
        break;
      end
    end
    n = -1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (pll_reset) begin
        n = k;
        break;
      end
    end
    check("to_period", 64'(n1 + n), 64'd116);
    check("to_relock_cnt4", 64'(relock_cnt), 64'd4);
    n = -1;
    for (int k = 1; k <= 260 * 116; k++) begin
      tick();
      if (relock_cnt == 8'd255) begin
        n = k;
        break;
      end
    end
    check("to_reaches_255", 64'(relock_cnt), 64'd255);
    repeat (300) tick();
    check("to_saturated", 64'(relock_cnt), 64'd255);
    check("to_ready_low", 64'(ps_bus.ready), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
